// File: rtl/beat_pkg.sv
// Shared constants for the note-duration beat encoder: nominal counts at 50 MHz,
// classification thresholds, beat codes and FSM state encodings.
package beat_pkg;

  localparam int unsigned CntW = 28;
  localparam logic [CntW-1:0] CntMax = '1;

  // Nominal durations in 50 MHz cycles.
  localparam int unsigned NomWhole = 80_000_000;
  localparam int unsigned NomHalf  = 40_000_000;
  localparam int unsigned NomQtr   = 20_000_000;
  localparam int unsigned Nom8th   = 10_000_000;
  localparam int unsigned Nom16th  = 5_000_000;
  localparam int unsigned Nom32nd  = 2_500_000;
  localparam int unsigned Nom64th  = 1_250_000;

  // Each threshold sits at 1.5x the shorter neighbouring nominal.
  localparam logic [CntW-1:0] ThrGlitch  = CntW'(Nom64th / 2);
  localparam logic [CntW-1:0] Thr64th    = CntW'(Nom64th + Nom64th / 2);
  localparam logic [CntW-1:0] Thr32nd    = CntW'(Nom32nd + Nom32nd / 2);
  localparam logic [CntW-1:0] Thr16th    = CntW'(Nom16th + Nom16th / 2);
  localparam logic [CntW-1:0] Thr8th     = CntW'(Nom8th + Nom8th / 2);
  localparam logic [CntW-1:0] ThrQtr     = CntW'(NomQtr + NomQtr / 2);
  localparam logic [CntW-1:0] ThrHalf    = CntW'(NomHalf + NomHalf / 2);
  localparam logic [CntW-1:0] ThrTooLong = CntW'(NomWhole + NomWhole / 2);

  localparam logic [3:0] BeatWhole = 4'h0;
  localparam logic [3:0] BeatHalf  = 4'h1;
  localparam logic [3:0] BeatQtr   = 4'h2;
  localparam logic [3:0] Beat8th   = 4'h3;
  localparam logic [3:0] Beat16th  = 4'h4;
  localparam logic [3:0] Beat32nd  = 4'h5;
  localparam logic [3:0] Beat64th  = 4'h6;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StMeasure = 2'd1;
  localparam logic [1:0] StEncode  = 2'd2;

endpackage

// File: rtl/beat_quantizer.sv
// Combinational comparator ladder mapping a cycle count to a beat code.
module beat_quantizer
  import beat_pkg::*;
(
  input  logic [CntW-1:0] d,
  output logic [3:0]      code,
  output logic            is_glitch,
  output logic            is_too_long
);

  always_comb begin
    code        = BeatWhole;
    is_glitch   = 1'b0;
    is_too_long = 1'b0;
    if (d < ThrGlitch) begin
      is_glitch = 1'b1;
    end else if (d < Thr64th) begin
      code = Beat64th;
    end else if (d < Thr32nd) begin
      code = Beat32nd;
    end else if (d < Thr16th) begin
      code = Beat16th;
    end else if (d < Thr8th) begin
      code = Beat8th;
    end else if (d < ThrQtr) begin
      code = BeatQtr;
    end else if (d < ThrHalf) begin
      code = BeatHalf;
    end else if (d < ThrTooLong) begin
      code = BeatWhole;
    end else begin
      is_too_long = 1'b1;
    end
  end

endmodule

// File: rtl/beat_encoder.sv
// Measures how long note_in is held and emits the matching beat code through
// a one-entry output slot, with overrun and too-long pulses.
module beat_encoder
  import beat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       note_in,
  output logic [3:0] beat,
  output logic       beat_valid,
  input  logic       beat_ready,
  output logic       overrun,
  output logic       too_long
);

  logic            note_q;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [3:0]      beat_q, beat_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            too_long_q, too_long_d;

  logic       rise, fall, accept;
  logic [3:0] q_code;
  logic       q_glitch, q_too_long;

  assign rise   = note_in & ~note_q;
  assign fall   = ~note_in & note_q;
  assign accept = valid_q & beat_ready;

  beat_quantizer u_quantizer (
    .d           (count_q),
    .code        (q_code),
    .is_glitch   (q_glitch),
    .is_too_long (q_too_long)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (rise) begin
          count_d = CntW'(1);
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (fall) begin
          state_d = StEncode;
        end else if (count_q != CntMax) begin
          count_d = count_q + CntW'(1);
        end
      end
      StEncode: begin
        // A re-press during ENCODE is measured straight away with no lost cycle.
        state_d = StIdle;
        if (rise) begin
          count_d = CntW'(1);
          state_d = StMeasure;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    beat_d     = beat_q;
    valid_d    = valid_q & ~accept;
    overrun_d  = 1'b0;
    too_long_d = 1'b0;
    if (state_q == StEncode) begin
      if (q_too_long) begin
        too_long_d = 1'b1;
      end else if (!q_glitch) begin
        if (!valid_q || accept) begin
          beat_d  = q_code;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // A note held through reset must be released and re-pressed to count.
      note_q     <= 1'b1;
      state_q    <= StIdle;
      count_q    <= '0;
      beat_q     <= BeatWhole;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      too_long_q <= 1'b0;
    end else begin
      note_q     <= note_in;
      state_q    <= state_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      too_long_q <= too_long_d;
    end
  end

  assign beat       = beat_q;
  assign beat_valid = valid_q;
  assign overrun    = overrun_q;
  assign too_long   = too_long_q;

endmodule

// File: tb/tb_beat_encoder.sv
// Directed bench for beat_encoder; long notes are shortened by overriding the
// duration counter partway through the note.
module tb_beat_encoder;

  logic       clk;
  logic       rst;
  logic       note_in;
  logic [3:0] beat;
  logic       beat_valid;
  logic       beat_ready;
  logic       overrun;
  logic       too_long;

  logic [27:0] q_d;
  logic [3:0]  q_code;
  logic        q_glitch;
  logic        q_too_long;

  logic [27:0] forced_cnt;
  int vectors;
  int miscompares;

  beat_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .note_in    (note_in),
    .beat       (beat),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .overrun    (overrun),
    .too_long   (too_long)
  );

  beat_quantizer u_quant (
    .d           (q_d),
    .code        (q_code),
    .is_glitch   (q_glitch),
    .is_too_long (q_too_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with count=1 already loaded; fakes the remaining hold so that the
  // falling edge is sampled with exactly d high samples. Returns in ENCODE.
  task automatic finish_note(input logic [27:0] d);
    tick();
    forced_cnt = d;
    force dut.count_q = forced_cnt;
    note_in = 1'b0;
    tick();
    release dut.count_q;
  endtask

  task automatic play_note(input logic [27:0] d);
    note_in = 1'b1;
    tick();
    finish_note(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    note_in = 1'b0;
    beat_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    vectors += 4;
    if (beat !== 4'h0) begin
      miscompares++; $display("FAIL reset_beat: got %h want 0", beat);
    end
    if (beat_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b want 0", beat_valid);
    end
    if (overrun !== 1'b0) begin
      miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun);
    end
    if (too_long !== 1'b0) begin
      miscompares++; $display("FAIL reset_too_long: got %b want 0", too_long);
    end
  endtask

  task automatic test_quantizer();
    logic [27:0] dv [18];
    logic [3:0]  cv [18];
    logic        gv [18];
    logic        tv [18];
    dv = '{28'd0, 28'd624_999, 28'd625_000, 28'd1_874_999, 28'd1_875_000,
           28'd3_749_999, 28'd3_750_000, 28'd7_499_999, 28'd7_500_000,
           28'd14_999_999, 28'd15_000_000, 28'd29_999_999, 28'd30_000_000,
           28'd59_999_999, 28'd60_000_000, 28'd119_999_999, 28'd120_000_000,
           28'hFFF_FFFF};
    cv = '{4'h0, 4'h0, 4'h6, 4'h6, 4'h5, 4'h5, 4'h4, 4'h4, 4'h3, 4'h3, 4'h2,
           4'h2, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    gv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 18; i++) begin
      q_d = dv[i];
      #1;
      vectors += 2;
      if (q_glitch !== gv[i]) begin
        miscompares++;
        $display("FAIL quant_glitch d=%0d: got %b want %b", dv[i], q_glitch, gv[i]);
      end
      if (q_too_long !== tv[i]) begin
        miscompares++;
        $display("FAIL quant_too_long d=%0d: got %b want %b", dv[i], q_too_long, tv[i]);
      end
      if (!gv[i] && !tv[i]) begin
        vectors++;
        if (q_code !== cv[i]) begin
          miscompares++;
          $display("FAIL quant_code d=%0d: got %h want %h", dv[i], q_code, cv[i]);
        end
      end
    end
  endtask

  task automatic test_eighth();
    beat_ready = 1'b1;
    play_note(28'd10_000_000);
    vectors++;
    if (beat_valid !== 1'b0) begin
      miscompares++; $display("FAIL eighth_early: got valid %b want 0", beat_valid);
    end
    tick();
    vectors += 3;
    if (beat_valid !== 1'b1) begin
      miscompares++; $display("FAIL eighth_valid: got %b want 1", beat_valid);
    end
    if (beat !== 4'h3) begin
      miscompares++; $display("FAIL eighth_beat: got %h want 3", beat);
    end
    if (overrun !== 1'b0 || too_long !== 1'b0) begin
      miscompares++;
      $display("FAIL eighth_pulses: got ovr %b tl %b want 0 0", overrun, too_long);
    end
    tick();
    vectors++;
    if (beat_valid !== 1'b0) begin
      miscompares++; $display("FAIL eighth_accept: got valid %b want 0", beat_valid);
    end
  endtask

  task automatic test_boundary();
    beat_ready = 1'b1;
    play_note(28'd1_874_999);
    tick();
    vectors += 2;
    if (beat_valid !== 1'b1 || beat !== 4'h6) begin
      miscompares++;
      $display("FAIL boundary_lo: got v%b beat %h want v1 beat 6", beat_valid, beat);
    end
    tick();
    play_note(28'd1_875_000);
    tick();
    if (beat_valid !== 1'b1 || beat !== 4'h5) begin
      miscompares++;
      $display("FAIL boundary_hi: got v%b beat %h want v1 beat 5", beat_valid, beat);
    end
    tick();
  endtask

  task automatic test_glitch();
    logic seen;
    beat_ready = 1'b1;
    seen = 1'b0;
    note_in = 1'b1;
    repeat (5) tick();
    note_in = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | beat_valid | overrun | too_long;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL glitch_short: got activity %b want 0", seen);
    end
    play_note(28'd600_000);
    repeat (3) begin
      tick();
      seen = seen | beat_valid | overrun | too_long;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL glitch_600k: got activity %b want 0", seen);
    end
  endtask

  task automatic test_too_long();
    beat_ready = 1'b1;
    play_note(28'd130_000_000);
    tick();
    vectors += 2;
    if (too_long !== 1'b1) begin
      miscompares++; $display("FAIL too_long_pulse: got %b want 1", too_long);
    end
    if (beat_valid !== 1'b0) begin
      miscompares++; $display("FAIL too_long_valid: got %b want 0", beat_valid);
    end
    tick();
    vectors++;
    if (too_long !== 1'b0) begin
      miscompares++; $display("FAIL too_long_width: got %b want 0", too_long);
    end
  endtask

  task automatic test_overrun();
    beat_ready = 1'b0;
    play_note(28'd80_000_000);
    tick();
    vectors++;
    if (beat_valid !== 1'b1 || beat !== 4'h0) begin
      miscompares++;
      $display("FAIL overrun_first: got v%b beat %h want v1 beat 0", beat_valid, beat);
    end
    tick();
    play_note(28'd40_000_000);
    tick();
    vectors += 2;
    if (overrun !== 1'b1) begin
      miscompares++; $display("FAIL overrun_pulse: got %b want 1", overrun);
    end
    if (beat_valid !== 1'b1 || beat !== 4'h0) begin
      miscompares++;
      $display("FAIL overrun_hold: got v%b beat %h want v1 beat 0", beat_valid, beat);
    end
    tick();
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++; $display("FAIL overrun_width: got %b want 0", overrun);
    end
    beat_ready = 1'b1;
    tick();
    vectors++;
    if (beat_valid !== 1'b0) begin
      miscompares++; $display("FAIL overrun_drain: got valid %b want 0", beat_valid);
    end
  endtask

  task automatic test_reset_held();
    logic seen;
    seen = 1'b0;
    beat_ready = 1'b1;
    note_in = 1'b1;
    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    repeat (20) tick();
    note_in = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | beat_valid | overrun | too_long;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL held_reset: got activity %b want 0", seen);
    end
    play_note(28'd5_000_000);
    tick();
    vectors++;
    if (beat_valid !== 1'b1 || beat !== 4'h4) begin
      miscompares++;
      $display("FAIL held_next: got v%b beat %h want v1 beat 4", beat_valid, beat);
    end
    tick();
    // A pending beat is lost if reset arrives before it is accepted.
    beat_ready = 1'b0;
    play_note(28'd10_000_000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (beat_valid !== 1'b0 || beat !== 4'h0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL pending_reset: got v%b beat %h ovr %b want v0 beat 0 ovr 0",
               beat_valid, beat, overrun);
    end
    beat_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    beat_ready = 1'b1;
    play_note(28'd20_000_000);
    note_in = 1'b1;
    tick();
    vectors++;
    if (beat_valid !== 1'b1 || beat !== 4'h2) begin
      miscompares++;
      $display("FAIL b2b_first: got v%b beat %h want v1 beat 2", beat_valid, beat);
    end
    finish_note(28'd2_500_000);
    tick();
    vectors += 2;
    if (beat_valid !== 1'b1 || beat !== 4'h5) begin
      miscompares++;
      $display("FAIL b2b_second: got v%b beat %h want v1 beat 5", beat_valid, beat);
    end
    if (overrun !== 1'b0) begin
      miscompares++; $display("FAIL b2b_overrun: got %b want 0", overrun);
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    q_d = '0;
    forced_cnt = '0;
    rst = 1'b1;
    note_in = 1'b0;
    beat_ready = 1'b0;
    test_reset();
    test_quantizer();
    test_eighth();
    test_boundary();
    test_glitch();
    test_too_long();
    test_overrun();
    test_reset_held();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
